regfile_master: RTL and testbench
=================================

# regfile_master

Initiator-side controller for the 4-entry, two-read/one-write register file. Accepts single read or write requests from a client over a valid/ready handshake, sequences the register file's write-enable and select lines, and returns both read operands on a buffered response channel. Sits between the client (a control FSM or test driver) and the register file instance; it is the only block allowed to drive the register file's `en`, `in_sel`, `in`, `out1_sel` and `out2_sel`.

## Interface
- `W`, 32, data width; must match the register file's `W`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; same net as the register file's `reset`.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr1`  in  2  write destination (write) or source 1 (read).
- `req_addr2`  in  2  source 2 (read); ignored for writes.
- `req_wdata`  in  W  write data; ignored for reads.
- `rsp_valid`  out  1  read response held.
- `rsp_ready`  in  1  client takes response.
- `rsp_data1`, `rsp_data2`  out  W  captured operands.
- `rf_en`, `rf_in_sel[1:0]`, `rf_in[W-1:0]`, `rf_out1_sel[1:0]`, `rf_out2_sel[1:0]`  out  register file controls.
- `rf_out1`, `rf_out2`  in  W  register file read data (combinational from its registers).

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch `req_we`, `req_addr1`, `req_addr2`, `req_wdata`; go to WRITE if `req_we`=1, else READ.
- WRITE: `rf_en`=1, `rf_in_sel`=latched addr1, `rf_in`=latched wdata for exactly one cycle; register file updates on the closing edge; next state IDLE.
- READ: `rf_out1_sel`=latched addr1, `rf_out2_sel`=latched addr2; on the closing edge capture `rf_out1`/`rf_out2` into `rsp_data1`/`rsp_data2`, set `rsp_valid`; next state RESP.
- RESP: `rsp_valid`=1, data stable; on `rsp_ready`=1 clear `rsp_valid`, go IDLE. No new request accepted until RESP exits.
- `req_ready` and `rf_en` are decoded from state only (no combinational path from any input).
- Select outputs hold the last latched addresses in all states; `rf_en`=0 in every state except WRITE.
- addr1 == addr2 on a read is legal; both outputs return the same register.
- A read issued immediately after a write to the same register returns the new value (write completes before READ begins).

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_data1`/`rsp_data2`=0, `rf_en`=0, all selects 0, `rf_in`=0.
- Write: accepted at edge N; `rf_en` high during cycle N..N+1; register visible after edge N+1; `req_ready` high again after edge N+1. Throughput one write per 2 cycles.
- Read: accepted at edge N; response captured at edge N+1; `rsp_valid` high from edge N+1 until the edge where `rsp_ready`=1. Minimum read turnaround 3 cycles (IDLE accept, READ, RESP with `rsp_ready`=1).
- Reset asserted mid-operation: state forced to IDLE immediately (async), `rf_en` drops in the same cycle so no partial write occurs, pending response discarded.
- `rsp_ready` outside RESP is ignored.

## Configuration
- `REGFILE_MASTER_STATS_EN`: when defined, adds outputs `wr_count[15:0]` and `rd_count[15:0]`, reset to 0, incremented on the edge leaving WRITE and on the response handshake in RESP respectively; wrap 0xFFFF -> 0x0000. When undefined, the ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset then idle: `rsp_valid`=0, `rf_en`=0, `req_ready`=1, all selects 0.
- Write 0xDEADBEEF to reg 2: `rf_en`=1 for exactly one cycle with `rf_in_sel`=2; read (2,2) afterwards returns 0xDEADBEEF on both data outputs.
- Write regs 0..3 with 0x11,0x22,0x33,0x44; read (3,0) -> `rsp_data1`=0x44, `rsp_data2`=0x11; hold `rsp_ready`=0 for 5 cycles -> `rsp_valid` and data stable, `req_ready`=0 throughout.
- Back-to-back write 0x5A to reg 1 then read (1,1) with `req_valid` held high: read returns 0x5A, no cycle with both `rf_en`=1 and `req_ready`=1.
- Assert `reset` during WRITE cycle of a write of 0x99 to reg 3: `rf_en` falls immediately, reg 3 reads 0 after reset release.
- With `REGFILE_MASTER_STATS_EN`: 3 writes + 2 reads -> `wr_count`=3, `rd_count`=2; preload counter to 0xFFFF via 65535 writes, one more -> 0x0000.

Source files
------------

// File: rtl/regfile_master_if.sv
// rtl/regfile_master_if.sv - client request/response and register-file control bundle for regfile_master
interface regfile_master_if #(
  parameter int W = 32
);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [1:0]   req_addr1;
  logic [1:0]   req_addr2;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data1;
  logic [W-1:0] rsp_data2;
  logic         rf_en;
  logic [1:0]   rf_in_sel;
  logic [W-1:0] rf_in;
  logic [1:0]   rf_out1_sel;
  logic [1:0]   rf_out2_sel;
  logic [W-1:0] rf_out1;
  logic [W-1:0] rf_out2;

  modport master (
    input  req_valid, req_we, req_addr1, req_addr2, req_wdata, rsp_ready, rf_out1, rf_out2,
    output req_ready, rsp_valid, rsp_data1, rsp_data2, rf_en, rf_in_sel, rf_in, rf_out1_sel, rf_out2_sel
  );

  modport slave (
    output req_valid, req_we, req_addr1, req_addr2, req_wdata, rsp_ready, rf_out1, rf_out2,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2, rf_en, rf_in_sel, rf_in, rf_out1_sel, rf_out2_sel
  );
endinterface

// File: rtl/regfile_master.sv
// rtl/regfile_master.sv - sequences single read/write requests onto a 4-entry 2R1W register file
// Defining REGFILE_MASTER_STATS_EN adds wr_count/rd_count transaction counters.
module regfile_master #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             reset,
  regfile_master_if.master bus
`ifdef REGFILE_MASTER_STATS_EN
  ,
  output logic [15:0]      wr_count,
  output logic [15:0]      rd_count
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t       state;
  state_t       next_state;
  logic         accept;
  logic [1:0]   addr1_q;
  logic [1:0]   addr2_q;
  logic [W-1:0] wdata_q;
  logic [W-1:0] data1_q;
  logic [W-1:0] data2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake and write enable come from state alone so no input can glitch them.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rf_en     = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = bus.req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        bus.rf_en  = 1'b1;
        next_state = IDLE;
      end
      READ: begin
        next_state = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr1_q <= '0;
      addr2_q <= '0;
      wdata_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      if (accept) begin
        addr1_q <= bus.req_addr1;
        addr2_q <= bus.req_addr2;
        wdata_q <= bus.req_wdata;
      end
      if (state == READ) begin
        data1_q <= bus.rf_out1;
        data2_q <= bus.rf_out2;
      end
    end
  end

  assign bus.rf_in_sel   = addr1_q;
  assign bus.rf_in       = wdata_q;
  assign bus.rf_out1_sel = addr1_q;
  assign bus.rf_out2_sel = addr2_q;
  assign bus.rsp_data1   = data1_q;
  assign bus.rsp_data2   = data2_q;

`ifdef REGFILE_MASTER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (state == WRITE) begin
        wr_count <= wr_count + 16'd1;
      end
      if (state == RESP && bus.rsp_ready) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_master.sv
// tb/tb_regfile_master.sv - randomized self-checking bench for regfile_master against a register-array model
module tb_regfile_master;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_master_if #(.W(W)) bus();

`ifdef REGFILE_MASTER_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
`endif

  regfile_master #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef REGFILE_MASTER_STATS_EN
    ,
    .wr_count (wr_count),
    .rd_count (rd_count)
`endif
  );

  // Register file instance stand-in: same reset net, combinational read ports.
  logic [W-1:0] rf_mem [4];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
    end else if (bus.rf_en) begin
      rf_mem[bus.rf_in_sel] <= bus.rf_in;
    end
  end
  assign bus.rf_out1 = rf_mem[bus.rf_out1_sel];
  assign bus.rf_out2 = rf_mem[bus.rf_out2_sel];

  logic [W-1:0] model [4];
  int vectors = 0;
  int miscompares = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) check("en_ready_excl", W'(bus.rf_en & bus.req_ready), '0);
  end

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model[i] = '0;
    exp_wr = 0;
    exp_rd = 0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    check("wr_idle_ready", W'(bus.req_ready), W'(1));
    check("wr_idle_en", W'(bus.rf_en), '0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr1 = a;
    bus.req_addr2 = 2'($urandom);
    bus.req_wdata = d;
    bus.rsp_ready = 1'($urandom);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr1 = 2'($urandom);
    bus.req_wdata = W'($urandom);
    @(negedge clk);
    check("wr_en", W'(bus.rf_en), W'(1));
    check("wr_sel", W'(bus.rf_in_sel), W'(a));
    check("wr_data", bus.rf_in, d);
    check("wr_busy", W'(bus.req_ready), '0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    model[a] = d;
    exp_wr++;
  endtask

  task automatic do_read(input logic [1:0] a1, input logic [1:0] a2, input int hold);
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    e1 = model[a1];
    e2 = model[a2];
    @(negedge clk);
    check("rd_idle_ready", W'(bus.req_ready), W'(1));
    check("rd_idle_rsp", W'(bus.rsp_valid), '0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr1 = a1;
    bus.req_addr2 = a2;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr1 = 2'($urandom);
    bus.req_addr2 = 2'($urandom);
    bus.rsp_ready = 1'($urandom);
    @(negedge clk);
    check("rd_sel1", W'(bus.rf_out1_sel), W'(a1));
    check("rd_sel2", W'(bus.rf_out2_sel), W'(a2));
    check("rd_no_rsp", W'(bus.rsp_valid), '0);
    check("rd_no_en", W'(bus.rf_en), '0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", W'(bus.rsp_valid), W'(1));
      check("hold_data1", bus.rsp_data1, e1);
      check("hold_data2", bus.rsp_data2, e2);
      check("hold_busy", W'(bus.req_ready), '0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rsp_valid", W'(bus.rsp_valid), W'(1));
    check("rsp_data1", bus.rsp_data1, e1);
    check("rsp_data2", bus.rsp_data2, e2);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    exp_rd++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr1 = '0;
    bus.req_addr2 = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    clear_model();

    repeat (3) @(negedge clk);
    check("rst_ready", W'(bus.req_ready), W'(1));
    check("rst_rsp_valid", W'(bus.rsp_valid), '0);
    check("rst_en", W'(bus.rf_en), '0);
    check("rst_sels", W'({bus.rf_in_sel, bus.rf_out1_sel, bus.rf_out2_sel}), '0);
    check("rst_rf_in", bus.rf_in, '0);
    check("rst_data", bus.rsp_data1 | bus.rsp_data2, '0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", W'(bus.req_ready), W'(1));
    check("idle_rsp_valid", W'(bus.rsp_valid), '0);

    do_write(2'd2, 32'hDEADBEEF);
    do_read(2'd2, 2'd2, 0);

    do_write(2'd0, 32'h11);
    do_write(2'd1, 32'h22);
    do_write(2'd2, 32'h33);
    do_write(2'd3, 32'h44);
    do_read(2'd3, 2'd0, 5);

    // Write then read with req_valid held high across both.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr1 = 2'd1;
    bus.req_wdata = 32'h5A;
    @(posedge clk); #1;
    bus.req_we    = 1'b0;
    bus.req_addr2 = 2'd1;
    @(negedge clk);
    check("b2b_wr_en", W'(bus.rf_en), W'(1));
    check("b2b_wr_busy", W'(bus.req_ready), '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_idle_ready", W'(bus.req_ready), W'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_rsp_valid", W'(bus.rsp_valid), W'(1));
    check("b2b_data1", bus.rsp_data1, 32'h5A);
    check("b2b_data2", bus.rsp_data2, 32'h5A);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    model[1] = 32'h5A;
    exp_wr++;
    exp_rd++;

`ifdef REGFILE_MASTER_STATS_EN
    @(negedge clk);
    check("wr_count", W'(wr_count), W'(16'(exp_wr)));
    check("rd_count", W'(rd_count), W'(16'(exp_rd)));
`endif

    // Reset lands in the middle of the WRITE cycle.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr1 = 2'd3;
    bus.req_wdata = 32'h99;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_wr_en_drop", W'(bus.rf_en), '0);
    check("rst_wr_ready", W'(bus.req_ready), W'(1));
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    do_read(2'd3, 2'd3, 1);

    // Reset while a response is pending discards it.
    do_write(2'd0, 32'hCAFE0001);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr1 = 2'd0;
    bus.req_addr2 = 2'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("resp_pending", W'(bus.rsp_valid), W'(1));
    reset = 1'b1;
    #1;
    check("rst_rsp_drop", W'(bus.rsp_valid), '0);
    check("rst_rsp_data", bus.rsp_data1, '0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        do_write(2'($urandom), W'($urandom));
      end else begin
        do_read(2'($urandom), 2'($urandom), int'($urandom_range(3, 0)));
      end
    end

`ifdef REGFILE_MASTER_STATS_EN
    @(negedge clk);
    check("wr_count_end", W'(wr_count), W'(16'(exp_wr)));
    check("rd_count_end", W'(rd_count), W'(16'(exp_rd)));
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
